// File: rtl/imem_loader_if.sv
// Program byte stream into the loader and byte write port out to the instruction memory.
interface imem_loader_if #(
    parameter int unsigned M = 10
);
    localparam int unsigned AW = M + 2;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport master (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: zero-fills the memory, streams a program into it,
// then releases the CPU from reset and measures its run time until halt.
module imem_loader #(
    parameter int unsigned M  = 10,
    parameter int unsigned CW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           cpu_rst,
    input  logic           is_halted,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [M+2:0]   byte_count,
    output logic [7:0]     checksum,
    output logic [CW-1:0]  run_cycles
);
    localparam int unsigned AW    = M + 2;
    localparam int unsigned CNTW  = M + 3;
    localparam int unsigned DEPTH = 4 * (2 ** M);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic [CNTW-1:0] byte_count_q, byte_count_d;
    logic [7:0]      checksum_q, checksum_d;
    logic [CW-1:0]   run_cycles_q, run_cycles_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            accept_c;

    // Next-state, datapath and status-flag decode.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        run_cycles_d = run_cycles_q;
        accept_c     = bus.in_valid & in_ready_q;

        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    state_d      = S_CLEAR;
                    clr_addr_d   = '0;
                    byte_count_d = '0;
                    checksum_d   = '0;
                    run_cycles_d = '0;
                end
            end
            S_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr_q;
                mem_wdata_d = 8'h00;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = S_LOAD;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    if (byte_count_q == CNTW'(DEPTH)) begin
                        // Program longer than the memory: nothing written, counters frozen.
                        state_d = S_ERROR;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = AW'(byte_count_q);
                        mem_wdata_d  = bus.in_data;
                        byte_count_d = byte_count_q + CNTW'(1);
                        checksum_d   = checksum_q + bus.in_data;
                        if (bus.in_last) begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_RUN: begin
                if (run_cycles_q != {CW{1'b1}}) begin
                    run_cycles_d = run_cycles_q + CW'(1);
                end
                if (is_halted) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state's decode.
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_CLEAR) || (state_d == S_LOAD);
        done_d     = (state_d == S_HALTED);
        error_d    = (state_d == S_ERROR);
        cpu_rst_d  = (state_d != S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            run_cycles_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            run_cycles_q <= run_cycles_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_rst_q    <= cpu_rst_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign byte_count    = byte_count_q;
    assign checksum      = checksum_q;
    assign run_cycles    = run_cycles_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with a 16-byte memory: table programs, random programs,
// overflow, start/reset corner cases.
module tb_imem_loader;
    localparam int unsigned M     = 2;
    localparam int unsigned AW    = M + 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 32;

    typedef logic [7:0] bq_t [$];
    typedef int         iq_t [$];

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          gap1;
        int          delay;
        logic [4:0]  exp_count;
        logic [7:0]  exp_sum;
        logic [31:0] exp_cycles;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          is_halted;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [M+2:0]  byte_count;
    logic [7:0]    checksum;
    logic [CW-1:0] run_cycles;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_a [$];
    logic [7:0] wr_d [$];

    imem_loader_if #(.M(M)) bus ();

    imem_loader #(.M(M), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .cpu_rst    (cpu_rst),
        .is_halted  (is_halted),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count),
        .checksum   (checksum),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: every write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_a.push_back(8'(bus.mem_addr));
            wr_d.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_sum(input bq_t p);
        int s = 0;
        foreach (p[i]) s += int'(p[i]);
        return 8'(s % 256);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_cpu_rst"},    64'(cpu_rst), 1);
        check({tag, "_busy"},       64'(busy), 0);
        check({tag, "_done"},       64'(done), 0);
        check({tag, "_error"},      64'(error), 0);
        check({tag, "_in_ready"},   64'(bus.in_ready), 0);
        check({tag, "_mem_we"},     64'(bus.mem_we), 0);
        check({tag, "_mem_addr"},   64'(bus.mem_addr), 0);
        check({tag, "_mem_wdata"},  64'(bus.mem_wdata), 0);
        check({tag, "_byte_count"}, 64'(byte_count), 0);
        check({tag, "_checksum"},   64'(checksum), 0);
        check({tag, "_run_cycles"}, 64'(run_cycles), 0);
    endtask

    // Pulse start, then verify the DEPTH zero writes and the busy/cpu_rst window.
    task automatic start_and_clear();
        int win_bad = 0;
        int clr_bad = 0;
        wr_a.delete();
        wr_d.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr_counters_zeroed", 64'({byte_count, checksum, run_cycles}), 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (busy !== 1'b1 || cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) win_bad++;
            tick();
        end
        check("clr_busy_window", 64'(win_bad), 0);
        check("clr_then_load_ready", 64'(bus.in_ready), 1);
        tick();
        check("clr_write_count", 64'(wr_a.size()), DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_a.size() <= k) clr_bad++;
            else if (wr_a[k] !== 8'(k) || wr_d[k] !== 8'h00) clr_bad++;
        end
        check("clr_write_content", 64'(clr_bad), 0);
        check("clr_strobe_idle", 64'(bus.mem_we), 0);
    endtask

    // Stream a program with per-byte idle gaps; each write must appear one cycle after its accept.
    task automatic load_bytes(input bq_t prog, input iq_t gaps);
        int wr_bad  = 0;
        int gap_bad = 0;
        int n = prog.size();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                bus.in_valid = 1'b0;
                tick();
                if (bus.mem_we !== 1'b0) gap_bad++;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = prog[i];
            bus.in_last  = (i == n - 1);
            tick();
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== prog[i]) wr_bad++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("load_write_timing", 64'(wr_bad), 0);
        check("load_gap_no_write", 64'(gap_bad), 0);
    endtask

    task automatic run_program(input bq_t prog, input iq_t gaps, input int delay,
                               input logic [4:0] ec, input logic [7:0] es, input logic [31:0] ecyc);
        int run_bad = 0;
        int img_bad = 0;
        logic [7:0] img [DEPTH];
        logic [7:0] exp_b;
        int n = prog.size();
        start_and_clear();
        load_bytes(prog, gaps);
        check("load_cpu_rst_release", 64'(cpu_rst), 0);
        check("load_busy_low", 64'(busy), 0);
        check("load_byte_count", 64'(byte_count), 64'(ec));
        check("load_checksum", 64'(checksum), 64'(es));
        is_halted = 1'b0;
        for (int d = 0; d < delay; d++) begin
            tick();
            if (cpu_rst !== 1'b0 || done !== 1'b0) run_bad++;
        end
        is_halted = 1'b1;
        tick();
        is_halted = 1'b0;
        check("run_no_early_halt", 64'(run_bad), 0);
        check("run_done", 64'(done), 1);
        check("run_cpu_rst_reassert", 64'(cpu_rst), 1);
        check("run_cycles", 64'(run_cycles), 64'(ecyc));
        for (int t = 0; t < 4; t++) begin
            is_halted = 1'($urandom);
            tick();
        end
        is_halted = 1'b0;
        check("halt_hold_state", 64'({done, cpu_rst, busy, error}), 64'(4'b1100));
        check("halt_hold_cycles", 64'(run_cycles), 64'(ecyc));
        check("halt_hold_count", 64'(byte_count), 64'(ec));
        check("prog_write_count", 64'(wr_a.size()), 64'(DEPTH + n));
        for (int i = 0; i < DEPTH; i++) img[i] = 'x;
        foreach (wr_a[k]) img[wr_a[k][AW-1:0]] = wr_d[k];
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = (i < n) ? prog[i] : 8'h00;
            if (img[i] !== exp_b) img_bad++;
        end
        check("prog_mem_image", 64'(img_bad), 0);
    endtask

    // Send DEPTH+1 bytes; the extra one must trip ERROR without a write.
    task automatic overflow_case(input logic last_on_extra);
        bq_t prog;
        bq_t first;
        int wr_bad = 0;
        for (int i = 0; i <= DEPTH; i++) prog.push_back(8'($urandom));
        for (int i = 0; i < DEPTH; i++) first.push_back(prog[i]);
        start_and_clear();
        for (int i = 0; i <= DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = prog[i];
            bus.in_last  = (i == DEPTH) ? last_on_extra : 1'b0;
            tick();
            if (i < DEPTH && (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== prog[i])) wr_bad++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("ovf_writes", 64'(wr_bad), 0);
        check("ovf_error", 64'(error), 1);
        check("ovf_no_extra_strobe", 64'(bus.mem_we), 0);
        check("ovf_byte_count", 64'(byte_count), DEPTH);
        check("ovf_checksum", 64'(checksum), 64'(model_sum(first)));
        check("ovf_flags", 64'({cpu_rst, busy, done, bus.in_ready}), 64'(4'b1000));
        is_halted = 1'b1;
        tick();
        is_halted = 1'b0;
        tick();
        check("ovf_write_total", 64'(wr_a.size()), 2 * DEPTH);
        check("ovf_error_holds", 64'(error), 1);
    endtask

    initial begin
        vec_t tbl [4];
        bq_t  prog;
        iq_t  gaps;
        logic [31:0] bv;
        int   n;
        int   delay;

        tbl[0] = '{32'h00A0_0513, 4, 0, 9, 5'd4, 8'hB8, 32'd10};
        tbl[1] = '{32'h0000_6655, 2, 2, 0, 5'd2, 8'hBB, 32'd1};
        tbl[2] = '{32'h0000_01FF, 2, 0, 3, 5'd2, 8'h00, 32'd4};
        tbl[3] = '{32'h0080_8080, 3, 1, 5, 5'd3, 8'h80, 32'd6};

        rst          = 1'b1;
        start        = 1'b0;
        is_halted    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        tick();
        tick();
        check_reset("por");
        rst = 1'b0;
        is_halted = 1'b1;
        tick();
        is_halted = 1'b0;
        check("idle_ignores_halt", 64'({done, cpu_rst}), 64'(2'b01));

        for (int v = 0; v < 4; v++) begin
            prog.delete();
            gaps.delete();
            bv = tbl[v].bytes;
            for (int i = 0; i < tbl[v].n; i++) begin
                prog.push_back(bv[8*i +: 8]);
                gaps.push_back((i == 1) ? tbl[v].gap1 : 0);
            end
            run_program(prog, gaps, tbl[v].delay, tbl[v].exp_count, tbl[v].exp_sum, tbl[v].exp_cycles);
        end

        for (int r = 0; r < 6; r++) begin
            prog.delete();
            gaps.delete();
            n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            delay = int'($urandom_range(0, 20));
            for (int i = 0; i < n; i++) begin
                prog.push_back(8'($urandom));
                gaps.push_back(int'($urandom_range(0, 2)));
            end
            run_program(prog, gaps, delay, 5'(n), model_sum(prog), 32'(delay + 1));
        end

        overflow_case(1'b0);
        overflow_case(1'b1);
        prog.delete();
        gaps.delete();
        prog.push_back(8'h42);
        gaps.push_back(0);
        run_program(prog, gaps, 2, 5'd1, 8'h42, 32'd3);

        // Reset during LOAD, with start ignored mid-load and start losing to rst.
        start_and_clear();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_data  = 8'hC3;
        tick();
        bus.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ignores_start", 64'({bus.in_ready, busy, byte_count}), 64'({1'b1, 1'b1, 5'd2}));
        check("load_keeps_checksum", 64'(checksum), 64'(8'h1D));
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check_reset("midload");
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("rst_beats_start", 64'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_start_after_rst", 64'({busy, cpu_rst}), 64'(2'b11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
